// File: rtl/pipe_pkg.sv
// Shared codes, FSM states and shadow-stage record for the pipeline hazard controller.
package pipe_pkg;

    localparam int STAGE_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_LD  = 2'b11;

    typedef enum logic {RUN, MWAIT} hz_state_t;

    typedef struct packed {
        logic                valid;
        logic                wreg;
        logic                m2reg;
        logic [STAGE_AW-1:0] rn;
    } stage_info_t;

    // r0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic stage_hit(input stage_info_t s, input logic [STAGE_AW-1:0] src,
                                       input logic use_src);
        return s.valid & s.wreg & (s.rn != '0) & (s.rn == src) & use_src;
    endfunction

endpackage

// File: rtl/hz_stage_track.sv
// Two-entry shadow of the EXE and MEM destination info, with hold and bubble insertion.
module hz_stage_track
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        hold,
    input  logic        insert_bubble,
    input  stage_info_t id_info,
    output stage_info_t exe_info,
    output stage_info_t mem_info
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            exe_info <= '0;
            mem_info <= '0;
        end else if (!hold) begin
            mem_info <= exe_info;
            exe_info <= insert_bubble ? '0 : id_info;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding selects, load-use interlock, branch flush and memory-wait freeze for the 5-stage pipe.
// Defining HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [REG_AW-1:0] id_rn,
    input  logic              id_btaken,
    input  logic              mem_busy,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic              wpcir,
    output logic              de_bubble,
    output logic              if_flush,
    output logic              freeze,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int TW = $clog2(WAIT_MAX + 1);

    hz_state_t           state, state_next;
    logic [TW-1:0]       timer;
    logic                timeout_q;
    stage_info_t         id_info, exe_info, mem_info;
    logic [STAGE_AW-1:0] rs, rt;
    logic                exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b, load_use;

    assign rs      = STAGE_AW'(id_rs);
    assign rt      = STAGE_AW'(id_rt);
    assign id_info = '{valid: id_valid, wreg: id_wreg, m2reg: id_m2reg, rn: STAGE_AW'(id_rn)};

    hz_stage_track u_track (
        .clk           (clk),
        .clrn          (clrn),
        .hold          (freeze),
        .insert_bubble (de_bubble | ~id_valid),
        .id_info       (id_info),
        .exe_info      (exe_info),
        .mem_info      (mem_info)
    );

    // A load still in EXE has no data yet, so it yields to an older MEM producer.
    function automatic logic [1:0] fwd_sel(input logic e_hit, input logic e_ld,
                                           input logic m_hit, input logic m_ld);
        if (e_hit && !e_ld)
            return FWD_EXE;
        else if (m_hit)
            return m_ld ? FWD_LD : FWD_MEM;
        else
            return FWD_REG;
    endfunction

    assign exe_hit_a = stage_hit(exe_info, rs, id_use_rs);
    assign exe_hit_b = stage_hit(exe_info, rt, id_use_rt);
    assign mem_hit_a = stage_hit(mem_info, rs, id_use_rs);
    assign mem_hit_b = stage_hit(mem_info, rt, id_use_rt);
    assign load_use  = id_valid & exe_info.m2reg & (exe_hit_a | exe_hit_b);

    assign fwda = fwd_sel(exe_hit_a, exe_info.m2reg, mem_hit_a, mem_info.m2reg);
    assign fwdb = fwd_sel(exe_hit_b, exe_info.m2reg, mem_hit_b, mem_info.m2reg);

    // Freeze outranks load-use, which outranks branch flush; everything idles while clrn is low.
    always_comb begin
        state_next = state;
        freeze     = 1'b0;
        wpcir      = 1'b1;
        de_bubble  = 1'b0;
        if_flush   = 1'b0;
        case (state)
            RUN:   if (mem_busy)  state_next = MWAIT;
            MWAIT: if (!mem_busy) state_next = RUN;
        endcase
        freeze = clrn & (mem_busy | ((state == MWAIT) & mem_busy));
        if (freeze) begin
            wpcir = 1'b0;
        end else if (load_use) begin
            wpcir     = 1'b0;
            de_bubble = 1'b1;
        end else begin
            if_flush = id_btaken & clrn;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= RUN;
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == MWAIT && mem_busy) begin
                if (timer == TW'(WAIT_MAX))
                    timeout_q <= 1'b1;
                else
                    timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((de_bubble | freeze) && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (if_flush && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against an instruction-history reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              clrn;
    logic              id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_btaken, mem_busy;
    logic [REG_AW-1:0] id_rs, id_rt, id_rn;
    logic [1:0]        fwda, fwdb;
    logic              wpcir, de_bubble, if_flush, freeze, mem_timeout;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wreg     (id_wreg),
        .id_m2reg    (id_m2reg),
        .id_rn       (id_rn),
        .id_btaken   (id_btaken),
        .mem_busy    (mem_busy),
        .fwda        (fwda),
        .fwdb        (fwdb),
        .wpcir       (wpcir),
        .de_bubble   (de_bubble),
        .if_flush    (if_flush),
        .freeze      (freeze),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    // One record per instruction that entered EXE; the newest is in EXE, the one before in MEM.
    typedef struct {
        bit v;
        bit w;
        bit ld;
        int rn;
    } rec_t;

    rec_t hist[$];
    int   run_len, m_stall, m_flush, checks, errors;
    bit   m_timeout;
    logic [1:0] e_fwda, e_fwdb;
    logic e_wpcir, e_bubble, e_flush, e_freeze;

    function automatic rec_t getRec(input int age);
        rec_t none = '{v: 1'b0, w: 1'b0, ld: 1'b0, rn: 0};
        if (age < hist.size())
            return hist[hist.size() - 1 - age];
        return none;
    endfunction

    function automatic bit produces(input rec_t r, input int src, input bit use_src);
        return use_src && r.v && r.w && r.rn != 0 && r.rn == src;
    endfunction

    function automatic logic [1:0] expFwd(input int src, input bit use_src);
        rec_t e = getRec(0);
        rec_t m = getRec(1);
        if (produces(e, src, use_src) && !e.ld)
            return 2'b01;
        if (produces(m, src, use_src))
            return m.ld ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        hist.delete();
        run_len   = 0;
        m_stall   = 0;
        m_flush   = 0;
        m_timeout = 1'b0;
    endtask

    task automatic checkOutput();
        bit lu;
        rec_t e = getRec(0);
        lu = id_valid && e.ld &&
             (produces(e, int'(id_rs), id_use_rs) || produces(e, int'(id_rt), id_use_rt));
        e_fwda   = expFwd(int'(id_rs), id_use_rs);
        e_fwdb   = expFwd(int'(id_rt), id_use_rt);
        e_freeze = mem_busy;
        e_wpcir  = !mem_busy && !lu;
        e_bubble = !mem_busy && lu;
        e_flush  = !mem_busy && !lu && id_btaken;
        checkVal("fwda", 32'(fwda), 32'(e_fwda));
        checkVal("fwdb", 32'(fwdb), 32'(e_fwdb));
        checkVal("wpcir", 32'(wpcir), 32'(e_wpcir));
        checkVal("de_bubble", 32'(de_bubble), 32'(e_bubble));
        checkVal("if_flush", 32'(if_flush), 32'(e_flush));
        checkVal("freeze", 32'(freeze), 32'(e_freeze));
        checkVal("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
        checkVal("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        checkVal("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic updateModel();
        rec_t r = '{v: 1'b0, w: 1'b0, ld: 1'b0, rn: 0};
        if (!mem_busy) begin
            if (id_valid && !e_bubble)
                r = '{v: 1'b1, w: id_wreg, ld: id_m2reg, rn: int'(id_rn)};
            hist.push_back(r);
            if (hist.size() > 4)
                void'(hist.pop_front());
        end
`ifdef HAZ_PERF_CNT_EN
        if ((e_bubble || e_freeze) && m_stall < (1 << CNT_W) - 1)
            m_stall++;
        if (e_flush && m_flush < (1 << CNT_W) - 1)
            m_flush++;
`endif
        run_len = mem_busy ? run_len + 1 : 0;
        if (run_len >= WAIT_MAX + 2)
            m_timeout = 1'b1;
    endtask

    task automatic setIdle();
        id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_wreg = 0; id_m2reg = 0; id_rn = '0; id_btaken = 0; mem_busy = 0;
    endtask

    // Entered and left at a falling edge: drive, check, clock, update the model.
    task automatic applyStimulus(input bit v, input int rs, input int rt, input bit urs,
                                 input bit urt, input bit w, input bit ld, input int rn,
                                 input bit bt, input bit busy);
        id_valid  = v;
        id_rs     = REG_AW'(rs);
        id_rt     = REG_AW'(rt);
        id_use_rs = urs;
        id_use_rt = urt;
        id_wreg   = w;
        id_m2reg  = ld;
        id_rn     = REG_AW'(rn);
        id_btaken = bt;
        mem_busy  = busy;
        #2;
        checkOutput();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    // Reset is held across a rising edge with busy/branch asserted; outputs must stay quiet.
    task automatic doReset();
        clrn = 1'b0;
        id_valid = 1; id_btaken = 1; mem_busy = 1;
        resetModel();
        #2;
        checkVal("rst_wpcir", 32'(wpcir), 32'd1);
        checkVal("rst_freeze", 32'(freeze), 32'd0);
        checkVal("rst_flush", 32'(if_flush), 32'd0);
        checkVal("rst_bubble", 32'(de_bubble), 32'd0);
        checkVal("rst_fwda", 32'(fwda), 32'd0);
        checkVal("rst_timeout", 32'(mem_timeout), 32'd0);
        checkVal("rst_stall", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        setIdle();
        clrn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clrn   = 1'b0;
        setIdle();
        resetModel();
        @(negedge clk);
        doReset();
        $display("[TB] directed scenarios");
        // add r3 then two readers of r3: EXE then MEM forwarding
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        applyStimulus(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        // lw r5 then a reader of rt=r5: one bubble, then load-data forwarding
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 5, 0, 0);
        applyStimulus(1, 1, 5, 0, 1, 1, 0, 6, 0, 0);
        applyStimulus(1, 1, 5, 0, 1, 1, 0, 6, 0, 0);
        // write to r0 never forwards or stalls
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // load-use coinciding with a taken branch: bubble first, flush next cycle
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 7, 0, 0);
        applyStimulus(1, 7, 0, 1, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 7, 0, 1, 0, 0, 0, 0, 1, 0);
        // short memory wait holds the shadow
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 9, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 9, 0, 1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
        // long memory wait sets the sticky timeout; reset mid-wait clears everything
        for (int i = 0; i < WAIT_MAX + 4; i++)
            applyStimulus(1, 0, 0, 0, 0, 1, 0, 4, 0, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 9, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        doReset();
        applyStimulus(1, 9, 9, 1, 1, 0, 0, 0, 0, 0);
        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) != 0,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                          int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
                          $urandom_range(0, 7) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
